// File: rtl/bert_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bert_mem_pkg
// Desc     : Buffer-select tags and BRAM memory map shared by fetch and collect.
// Revision : 1.0
// ============================================================================
package bert_mem_pkg;

    localparam int SEL_WIDTH = 2;

    typedef enum logic [SEL_WIDTH-1:0] {
        BUF_WEIGHT = 2'b00,
        BUF_K      = 2'b01,
        BUF_V      = 2'b10
    } buf_sel_e;

    localparam logic [15:0] C_WEIGHT_BASE_ADDR = 16'h0000;
    localparam logic [15:0] C_K_BASE_ADDR      = 16'h4000;
    localparam logic [15:0] C_V_BASE_ADDR      = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/tile_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : tile_fifo2
// Desc     : Two-entry valid/ready FIFO, registered head, reports dropped pushes.
// Revision : 1.0
// ============================================================================
module tile_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_push_drop,
    output logic [1:0]       o_count_next
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             w_pop;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        o_push_drop = 1'b0;
        w_pop       = (count_q != 2'd0) && i_ready;
        if (i_flush) begin
            count_d = 2'd0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case ({i_push, w_pop})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = i_push_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = i_push_data;
                    end
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    case (count_q)
                        2'd0: begin
                            head_d  = i_push_data;
                            count_d = 2'd1;
                        end
                        2'd1: begin
                            tail_d  = i_push_data;
                            count_d = 2'd2;
                        end
                        default: o_push_drop = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
        o_count_next = count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_valid = (count_q != 2'd0);
    assign o_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/tile_collector.sv
`default_nettype none
// ============================================================================
// Module   : tile_collector
// Desc     : Aligns BRAM read data to fetch strobes and packs words into tagged tiles.
// Revision : 1.0
// ============================================================================
module tile_collector
    import bert_mem_pkg::*;
#(
    parameter int DATA_WIDTH           = 64,
    parameter int NUM_FETCHES_PER_TILE = 2,
    parameter int READ_LATENCY         = 1,
    parameter int SEL_WIDTH            = bert_mem_pkg::SEL_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush,
    input  logic                                       bram_en,
    input  logic [SEL_WIDTH-1:0]                       buffer_select,
    input  logic [DATA_WIDTH-1:0]                      bram_rdata,
    output logic                                       tile_valid,
    output logic [DATA_WIDTH*NUM_FETCHES_PER_TILE-1:0] tile_data,
    output logic [SEL_WIDTH-1:0]                       tile_src,
    input  logic                                       tile_ready,
    output logic                                       can_fetch,
    output logic                                       overflow_err
);

    localparam int C_CNT_W  = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;
    localparam int C_TILE_W = DATA_WIDTH * NUM_FETCHES_PER_TILE;
    localparam int C_PAY_W  = SEL_WIDTH + C_TILE_W;
    localparam logic [C_CNT_W-1:0] C_LAST_WORD = C_CNT_W'(NUM_FETCHES_PER_TILE - 1);
    localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);

    logic [READ_LATENCY-1:0]                 en_pipe_q, en_pipe_d;
    logic [READ_LATENCY-1:0][SEL_WIDTH-1:0]  sel_pipe_q, sel_pipe_d;
    logic [C_CNT_W-1:0]                      word_cnt_q, word_cnt_d;
    logic [SEL_WIDTH-1:0]                    tag_q, tag_d;
    logic [NUM_FETCHES_PER_TILE-1:0][DATA_WIDTH-1:0] asm_q, asm_d;
    logic                                    overflow_q, overflow_d;
    logic                                    can_fetch_q, can_fetch_d;

    logic                 w_en_d;
    logic [SEL_WIDTH-1:0] w_sel_d;
    logic                 w_push;
    logic [C_PAY_W-1:0]   w_push_payload;
    logic [C_PAY_W-1:0]   w_head_payload;
    logic                 w_push_drop;
    logic [1:0]           w_count_next;
    logic                 w_busy_next;

    assign w_en_d  = en_pipe_q[READ_LATENCY-1];
    assign w_sel_d = sel_pipe_q[READ_LATENCY-1];

    // Flush wins over everything: the strobe presented alongside it never enters the pipeline.
    always_comb begin
        en_pipe_d  = '0;
        sel_pipe_d = '0;
        word_cnt_d = word_cnt_q;
        tag_d      = tag_q;
        asm_d      = asm_q;
        w_push     = 1'b0;
        if (flush) begin
            word_cnt_d = '0;
            tag_d      = '0;
            asm_d      = '0;
        end else begin
            en_pipe_d[0]  = bram_en;
            sel_pipe_d[0] = buffer_select;
            for (int i = 1; i < READ_LATENCY; i++) begin
                en_pipe_d[i]  = en_pipe_q[i-1];
                sel_pipe_d[i] = sel_pipe_q[i-1];
            end
            if (w_en_d) begin
                asm_d[word_cnt_q] = bram_rdata;
                if (word_cnt_q == '0) begin
                    tag_d = w_sel_d;
                end
                if (word_cnt_q == C_LAST_WORD) begin
                    w_push     = 1'b1;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + C_ONE;
                end
            end
        end
        w_push_payload = {tag_d, asm_d};
    end

    // Look ahead at next-cycle occupancy so can_fetch falls right after a fetch starts.
    always_comb begin
        w_busy_next = (word_cnt_d != '0) || (|en_pipe_d);
        can_fetch_d = ({1'b0, w_count_next} + {2'b00, w_busy_next}) < 3'd2;
        overflow_d  = flush ? 1'b0 : (overflow_q | w_push_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe_q   <= '0;
            sel_pipe_q  <= '0;
            word_cnt_q  <= '0;
            tag_q       <= '0;
            asm_q       <= '0;
            overflow_q  <= 1'b0;
            can_fetch_q <= 1'b1;
        end else begin
            en_pipe_q   <= en_pipe_d;
            sel_pipe_q  <= sel_pipe_d;
            word_cnt_q  <= word_cnt_d;
            tag_q       <= tag_d;
            asm_q       <= asm_d;
            overflow_q  <= overflow_d;
            can_fetch_q <= can_fetch_d;
        end
    end

    tile_fifo2 #(
        .WIDTH (C_PAY_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_push       (w_push),
        .i_push_data  (w_push_payload),
        .i_ready      (tile_ready),
        .o_valid      (tile_valid),
        .o_data       (w_head_payload),
        .o_push_drop  (w_push_drop),
        .o_count_next (w_count_next)
    );

    assign tile_data    = w_head_payload[C_TILE_W-1:0];
    assign tile_src     = w_head_payload[C_PAY_W-1:C_TILE_W];
    assign can_fetch    = can_fetch_q;
    assign overflow_err = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_collector
// Desc     : Directed self-checking bench for tile_collector (default and N=4/RL=2).
// Revision : 1.0
// ============================================================================
module tb_tile_collector;
    import bert_mem_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, flush, bram_en, tile_ready;
    logic [1:0]   buffer_select;
    logic [63:0]  bram_rdata;
    logic         tile_valid, can_fetch, overflow_err;
    logic [127:0] tile_data;
    logic [1:0]   tile_src;

    logic         rst_n2, flush2, bram_en2, tile_ready2;
    logic [1:0]   buffer_select2;
    logic [63:0]  bram_rdata2;
    logic         tile_valid2, can_fetch2, overflow_err2;
    logic [255:0] tile_data2;
    logic [1:0]   tile_src2;

    int checks = 0;
    int errors = 0;

    logic [63:0] w [6];
    logic [1:0]  ts [3];
    logic [63:0] v [4];

    always #5 clk = ~clk;

    tile_collector dut (
        .clk (clk), .rst_n (rst_n), .flush (flush), .bram_en (bram_en),
        .buffer_select (buffer_select), .bram_rdata (bram_rdata),
        .tile_valid (tile_valid), .tile_data (tile_data), .tile_src (tile_src),
        .tile_ready (tile_ready), .can_fetch (can_fetch), .overflow_err (overflow_err)
    );

    tile_collector #(
        .DATA_WIDTH (64), .NUM_FETCHES_PER_TILE (4), .READ_LATENCY (2), .SEL_WIDTH (2)
    ) dut2 (
        .clk (clk), .rst_n (rst_n2), .flush (flush2), .bram_en (bram_en2),
        .buffer_select (buffer_select2), .bram_rdata (bram_rdata2),
        .tile_valid (tile_valid2), .tile_data (tile_data2), .tile_src (tile_src2),
        .tile_ready (tile_ready2), .can_fetch (can_fetch2), .overflow_err (overflow_err2)
    );

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        w[0] = 64'h0A0A_0000_0000_0001; w[1] = 64'h0B0B_0000_0000_0002;
        w[2] = 64'h1A1A_0000_0000_0003; w[3] = 64'h1B1B_0000_0000_0004;
        w[4] = 64'h2A2A_0000_0000_0005; w[5] = 64'h2B2B_0000_0000_0006;
        ts[0] = BUF_WEIGHT; ts[1] = BUF_K; ts[2] = BUF_V;
        v[0] = 64'h1111_2222_3333_4444; v[1] = 64'h5555_6666_7777_8888;
        v[2] = 64'h9999_AAAA_BBBB_CCCC; v[3] = 64'hDDDD_EEEE_FFFF_0123;

        rst_n = 1'b0; flush = 1'b0; bram_en = 1'b0; tile_ready = 1'b0;
        buffer_select = 2'b00; bram_rdata = '0;
        rst_n2 = 1'b0; flush2 = 1'b0; bram_en2 = 1'b0; tile_ready2 = 1'b0;
        buffer_select2 = 2'b00; bram_rdata2 = '0;
        tick();
        tick();

        // Reset values
        chk("rst_valid", tile_valid, 0);
        chk("rst_data", tile_data, 0);
        chk("rst_src", tile_src, 0);
        chk("rst_can_fetch", can_fetch, 1);
        chk("rst_overflow", overflow_err, 0);
        chk("rst2_can_fetch", can_fetch2, 1);
        rst_n = 1'b1; rst_n2 = 1'b1;
        tick();

        // Single tile: en cycles 0-1, data A/B in cycles 1-2, valid in cycle 3
        tile_ready = 1'b1; bram_en = 1'b1; buffer_select = BUF_K;
        tick();
        bram_rdata = 64'hAAAA_AAAA_0000_000A;
        tick();
        bram_en = 1'b0; buffer_select = 2'b00; bram_rdata = 64'hBBBB_BBBB_0000_000B;
        chk("t1_valid_c2", tile_valid, 0);
        tick();
        bram_rdata = '0;
        chk("t1_valid_c3", tile_valid, 1);
        chk("t1_data", tile_data, {64'hBBBB_BBBB_0000_000B, 64'hAAAA_AAAA_0000_000A});
        chk("t1_src", tile_src, 2'b01);
        tick();
        chk("t1_valid_c4", tile_valid, 0);
        chk("t1_can_fetch_c4", can_fetch, 1);

        // Backpressure: three tiles, no consumer; third is dropped
        tile_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bram_en = (i < 6);
            buffer_select = ts[(i < 6) ? i / 2 : 2];
            bram_rdata = (i > 0) ? w[i-1] : 64'h0;
            tick();
        end
        bram_en = 1'b0; bram_rdata = '0;
        chk("bp_valid", tile_valid, 1);
        chk("bp_head0_data", tile_data, {w[1], w[0]});
        chk("bp_head0_src", tile_src, 2'b00);
        chk("bp_overflow", overflow_err, 1);
        chk("bp_can_fetch", can_fetch, 0);
        tick();
        chk("bp_head0_stable", tile_data, {w[1], w[0]});
        tile_ready = 1'b1;
        tick();
        chk("bp_head1_data", tile_data, {w[3], w[2]});
        chk("bp_head1_src", tile_src, 2'b01);
        tick();
        chk("bp_empty", tile_valid, 0);
        chk("bp_overflow_sticky", overflow_err, 1);
        chk("bp_can_fetch_back", can_fetch, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("bp_flush_overflow", overflow_err, 0);

        // Simultaneous push/pop on full FIFO
        tile_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bram_en = 1'b1;
            buffer_select = ts[i / 2];
            bram_rdata = (i > 0) ? w[i-1] : 64'h0;
            tick();
        end
        bram_en = 1'b0; bram_rdata = w[5]; tile_ready = 1'b1;
        chk("pp_head0", tile_data, {w[1], w[0]});
        tick();
        bram_rdata = '0;
        chk("pp_head1", tile_data, {w[3], w[2]});
        chk("pp_no_overflow", overflow_err, 0);
        tick();
        chk("pp_head2", tile_data, {w[5], w[4]});
        chk("pp_head2_src", tile_src, 2'b10);
        chk("pp_head2_valid", tile_valid, 1);
        tick();
        chk("pp_empty", tile_valid, 0);

        // Tag latch: sel changes between words
        bram_en = 1'b1; buffer_select = BUF_WEIGHT;
        tick();
        buffer_select = BUF_V; bram_rdata = 64'hC4C4_0000_0000_00C1;
        tick();
        bram_en = 1'b0; bram_rdata = 64'hC4C4_0000_0000_00C2;
        tick();
        bram_rdata = '0;
        chk("tag_src", tile_src, 2'b00);
        chk("tag_data", tile_data, {64'hC4C4_0000_0000_00C2, 64'hC4C4_0000_0000_00C1});
        tick();

        // Flush mid-tile with one tile buffered; strobe and pop in flush cycle ignored
        tile_ready = 1'b0; bram_en = 1'b1; buffer_select = BUF_K;
        tick();
        bram_rdata = 64'h5050_0000_0000_0001;
        tick();
        bram_en = 1'b0; bram_rdata = 64'h5050_0000_0000_0002;
        tick();
        bram_rdata = '0; bram_en = 1'b1; buffer_select = BUF_WEIGHT;
        chk("fl_buffered", tile_valid, 1);
        tick();
        bram_en = 1'b0; bram_rdata = 64'h7070_0000_0000_0007;
        tick();
        flush = 1'b1; bram_en = 1'b1; tile_ready = 1'b1; bram_rdata = '0;
        tick();
        flush = 1'b0; bram_en = 1'b0; tile_ready = 1'b0; bram_rdata = 64'hEEEE_0000_0000_000E;
        chk("fl_valid", tile_valid, 0);
        chk("fl_can_fetch", can_fetch, 1);
        chk("fl_overflow", overflow_err, 0);
        tick();
        bram_rdata = '0; bram_en = 1'b1; buffer_select = BUF_V;
        tick();
        bram_rdata = 64'hC0C0_0000_0000_000C;
        tick();
        bram_en = 1'b0; bram_rdata = 64'hD0D0_0000_0000_000D;
        chk("fl_fresh_not_yet", tile_valid, 0);
        tick();
        bram_rdata = '0;
        chk("fl_fresh_valid", tile_valid, 1);
        chk("fl_fresh_data", tile_data, {64'hD0D0_0000_0000_000D, 64'hC0C0_0000_0000_000C});
        chk("fl_fresh_src", tile_src, 2'b10);
        tile_ready = 1'b1;
        tick();

        // N=4, READ_LATENCY=2: en cycles 0-3, data cycles 2-5, valid in cycle 6
        tile_ready2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bram_en2 = (i < 4);
            buffer_select2 = BUF_K;
            bram_rdata2 = (i >= 2) ? v[i-2] : 64'h0;
            if (i == 5) chk("p_valid_c5", tile_valid2, 0);
            tick();
        end
        bram_en2 = 1'b0; bram_rdata2 = '0;
        chk("p_valid_c6", tile_valid2, 1);
        chk("p_data", tile_data2, {v[3], v[2], v[1], v[0]});
        chk("p_src", tile_src2, 2'b01);
        tick();
        bram_en2 = 1'b1; buffer_select2 = BUF_V;
        tick();
        chk("p_can_fetch_drop", can_fetch2, 0);
        chk("p_still_valid", tile_valid2, 1);
        #3;
        rst_n2 = 1'b0;
        #1;
        chk("ar_valid", tile_valid2, 0);
        chk("ar_data", tile_data2, 0);
        chk("ar_src", tile_src2, 0);
        chk("ar_can_fetch", can_fetch2, 1);
        chk("ar_overflow", overflow_err2, 0);
        bram_en2 = 1'b0;
        tick();
        rst_n2 = 1'b1;
        tick();
        tick();
        tick();
        chk("ar_no_stale", tile_valid2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
